// File: rtl/mult_div_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
package mult_div_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/sign_fix64.sv
// Conditional two's-complement negate of a W-bit value; purely combinational, 0 cycles.
// No flow control: output follows inputs.
module sign_fix64 #(
    parameter int W = 64
) (
    input  logic         neg,
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);

    assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/mult_div_ctrl.sv
// HI/LO multiply/divide sequencer: signed shift-add MULT and restoring DIV (DIV built only with MULTDIV_DIV_EN).
// Latency WIDTH+2 cycles start->done/hi_lo_write; divide-by-zero and disabled DIV finish after 1 cycle.
// No backpressure: busy stalls the main FSM and start is ignored unless idle.
module mult_div_ctrl
    import mult_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             hi_lo_write,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_e             state;
    logic [CW-1:0]      count;
    logic               sa, sb, wr_pend, dz_pend;
    logic [WIDTH-1:0]   opnd, shreg;
    logic [2*WIDTH-1:0] acc, a_abs, b_abs, res_in, res;
    logic [WIDTH:0]     mul_sum;

    // Sign-extended operands negated when negative leave |x| in the low half.
    sign_fix64 #(.W(2*WIDTH)) u_abs_a (.neg(a_in[WIDTH-1]), .x({{WIDTH{a_in[WIDTH-1]}}, a_in}), .y(a_abs));
    sign_fix64 #(.W(2*WIDTH)) u_abs_b (.neg(b_in[WIDTH-1]), .x({{WIDTH{b_in[WIDTH-1]}}, b_in}), .y(b_abs));

    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (shreg[0] ? {1'b0, opnd} : '0);

`ifdef MULTDIV_DIV_EN
    logic               op_q;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH:0]     rem_sh, diff;
    logic [2*WIDTH-1:0] rem_fix;
    logic               unused_bits;

    // shreg holds the dividend during DIV and collects quotient bits from the LSB end.
    assign rem_sh = {rem, shreg[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, opnd};
    assign res_in = op_q ? {{WIDTH{1'b0}}, shreg} : acc;

    sign_fix64 #(.W(2*WIDTH)) u_fix_rem (.neg(sa), .x({{WIDTH{1'b0}}, rem}), .y(rem_fix));

    assign unused_bits = ^{a_abs[2*WIDTH-1:WIDTH], b_abs[2*WIDTH-1:WIDTH], rem_fix[2*WIDTH-1:WIDTH]};
`else
    logic unused_bits;

    assign res_in      = acc;
    assign unused_bits = ^{a_abs[2*WIDTH-1:WIDTH], b_abs[2*WIDTH-1:WIDTH]};
`endif

    sign_fix64 #(.W(2*WIDTH)) u_fix_res (.neg(sa ^ sb), .x(res_in), .y(res));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            count       <= '0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            wr_pend     <= 1'b0;
            dz_pend     <= 1'b0;
            opnd        <= '0;
            shreg       <= '0;
            acc         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi_lo_write <= 1'b0;
            div_zero    <= 1'b0;
            hi_out      <= '0;
            lo_out      <= '0;
`ifdef MULTDIV_DIV_EN
            op_q        <= 1'b0;
            rem         <= '0;
`endif
        end else begin
            done        <= 1'b0;
            hi_lo_write <= 1'b0;
            div_zero    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sa    <= a_in[WIDTH-1];
                        sb    <= b_in[WIDTH-1];
                        opnd  <= (op == OP_DIV) ? b_abs[WIDTH-1:0] : a_abs[WIDTH-1:0];
                        shreg <= (op == OP_DIV) ? a_abs[WIDTH-1:0] : b_abs[WIDTH-1:0];
                        acc   <= '0;
                        count <= CW'(WIDTH);
                        busy  <= 1'b1;
`ifdef MULTDIV_DIV_EN
                        op_q  <= op;
                        rem   <= '0;
                        if (op == OP_DIV && b_in == '0) begin
                            state   <= ST_DONE;
                            wr_pend <= 1'b0;
                            dz_pend <= 1'b1;
                        end else begin
                            state   <= ST_RUN;
                            wr_pend <= 1'b1;
                            dz_pend <= 1'b0;
                        end
`else
                        dz_pend <= 1'b0;
                        if (op == OP_DIV) begin
                            state   <= ST_DONE;
                            wr_pend <= 1'b0;
                        end else begin
                            state   <= ST_RUN;
                            wr_pend <= 1'b1;
                        end
`endif
                    end
                end
                ST_RUN: begin
                    count <= count - CW'(1);
                    if (count == CW'(1))
                        state <= ST_FIX;
`ifdef MULTDIV_DIV_EN
                    if (op_q) begin
                        if (diff[WIDTH]) begin
                            rem   <= rem_sh[WIDTH-1:0];
                            shreg <= {shreg[WIDTH-2:0], 1'b0};
                        end else begin
                            rem   <= diff[WIDTH-1:0];
                            shreg <= {shreg[WIDTH-2:0], 1'b1};
                        end
                    end else begin
                        acc   <= {mul_sum, acc[WIDTH-1:1]};
                        shreg <= {1'b0, shreg[WIDTH-1:1]};
                    end
`else
                    acc   <= {mul_sum, acc[WIDTH-1:1]};
                    shreg <= {1'b0, shreg[WIDTH-1:1]};
`endif
                end
                ST_FIX: begin
                    lo_out <= res[WIDTH-1:0];
`ifdef MULTDIV_DIV_EN
                    hi_out <= op_q ? rem_fix[WIDTH-1:0] : res[2*WIDTH-1:WIDTH];
`else
                    hi_out <= res[2*WIDTH-1:WIDTH];
`endif
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    hi_lo_write <= wr_pend;
                    div_zero    <= dz_pend;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed-vector bench for mult_div_ctrl; DIV expectations follow MULTDIV_DIV_EN.
module tb_mult_div_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a_in, b_in;
    logic        busy, done, hi_lo_write, div_zero;
    logic [31:0] hi_out, lo_out;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mult_div_ctrl #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a_in        (a_in),
        .b_in        (b_in),
        .busy        (busy),
        .done        (done),
        .hi_lo_write (hi_lo_write),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .div_zero    (div_zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one operation and follows it to its done pulse (bounded).
    task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int wr, output int dz, output int busy_lo);
        @(negedge clk);
        op = o; a_in = a; b_in = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = $urandom_range(1); a_in = $urandom; b_in = $urandom;
        lat = -1; wr = 0; dz = 0; busy_lo = 0;
        for (int k = 1; k <= 60; k++) begin
            if (!busy) busy_lo++;
            @(posedge clk); #1;
            wr += int'(hi_lo_write);
            dz += int'(div_zero);
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat, wr, dz, bl;
        do_op(1'b0, a, b, lat, wr, dz, bl);
        check({tag, "_lat"}, 64'(lat), 64'd34);
        check({tag, "_wr"}, 64'(wr), 64'd1);
        check({tag, "_hi"}, 64'(hi_out), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo_out), 64'(exp_lo));
    endtask

    initial begin
        int lat, wr, dz, bl, dones;
        reset = 1'b0; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_wr", 64'(hi_lo_write), 64'd0);
        check("rst_dz", 64'(div_zero), 64'd0);
        check("rst_hi", 64'(hi_out), 64'd0);
        check("rst_lo", 64'(lo_out), 64'd0);
        reset = 1'b1;

        // 7 * -3 = -21
        do_op(1'b0, 32'd7, 32'hFFFF_FFFD, lat, wr, dz, bl);
        check("m1_lat", 64'(lat), 64'd34);
        check("m1_wr", 64'(wr), 64'd1);
        check("m1_dz", 64'(dz), 64'd0);
        check("m1_busy_lo", 64'(bl), 64'd0);
        check("m1_busy_at_done", 64'(busy), 64'd0);
        check("m1_hi", 64'(hi_out), 64'hFFFF_FFFF);
        check("m1_lo", 64'(lo_out), 64'hFFFF_FFEB);

        run_mult("m2", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_mult("m3", 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_001E);
        run_mult("m4", 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780);
        run_mult("m5", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);

`ifdef MULTDIV_DIV_EN
        do_op(1'b1, 32'd100, 32'd7, lat, wr, dz, bl);
        check("d1_lat", 64'(lat), 64'd34);
        check("d1_wr", 64'(wr), 64'd1);
        check("d1_lo", 64'(lo_out), 64'd14);
        check("d1_hi", 64'(hi_out), 64'd2);
        do_op(1'b1, 32'hFFFF_FF9C, 32'd7, lat, wr, dz, bl);
        check("d2_lo", 64'(lo_out), 64'hFFFF_FFF2);
        check("d2_hi", 64'(hi_out), 64'hFFFF_FFFE);
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, wr, dz, bl);
        check("d3_lo", 64'(lo_out), 64'h8000_0000);
        check("d3_hi", 64'(hi_out), 64'h0);
        do_op(1'b1, 32'd100, 32'hFFFF_FFF9, lat, wr, dz, bl);
        check("d4_lo", 64'(lo_out), 64'hFFFF_FFF2);
        check("d4_hi", 64'(hi_out), 64'd2);
        do_op(1'b1, 32'd5, 32'd0, lat, wr, dz, bl);
        check("dz_lat", 64'(lat), 64'd1);
        check("dz_pulse", 64'(dz), 64'd1);
        check("dz_wr", 64'(wr), 64'd0);
        check("dz_busy_lo", 64'(bl), 64'd0);
        check("dz_hi_keep", 64'(hi_out), 64'd2);
        check("dz_lo_keep", 64'(lo_out), 64'hFFFF_FFF2);
`else
        do_op(1'b1, 32'd100, 32'd7, lat, wr, dz, bl);
        check("nodiv_lat", 64'(lat), 64'd1);
        check("nodiv_wr", 64'(wr), 64'd0);
        check("nodiv_dz", 64'(dz), 64'd0);
        check("nodiv_hi_keep", 64'(hi_out), 64'h0);
        check("nodiv_lo_keep", 64'(lo_out), 64'h1);
`endif

        // start re-asserted mid-operation must not spawn a second run
        @(negedge clk);
        op = 1'b0; a_in = 32'd3; b_in = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        for (int k = 1; k <= 80; k++) begin
            if (k == 5) begin
                start = 1'b1; op = 1'b0; a_in = 32'd9; b_in = 32'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            dones += int'(done);
        end
        check("ign_dones", 64'(dones), 64'd1);
        check("ign_hi", 64'(hi_out), 64'd0);
        check("ign_lo", 64'(lo_out), 64'd12);

        // reset mid-operation aborts with no write
        @(negedge clk);
        op = 1'b0; a_in = 32'd7; b_in = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi_out), 64'd0);
        check("abort_lo", 64'(lo_out), 64'd0);
        wr = 0; dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            wr += int'(hi_lo_write);
            dones += int'(done);
        end
        check("abort_no_wr", 64'(wr), 64'd0);
        check("abort_no_done", 64'(dones), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_div_ctrl.md
# mult_div_ctrl

Iterative multiply/divide sequencer that owns the HI/LO result path of the multicycle CPU. The main control FSM pulses `start` with operands taken from the A and B registers. The block runs a 32-step shift-add multiply or restoring divide, then issues one write strobe with the HI/LO values. It stalls the main FSM through `busy` and reports divide-by-zero for the exception logic (EPC path).

## Interface
Parameters:
- `WIDTH`, 32, operand width; iteration count equals `WIDTH`, counter is `$clog2(WIDTH)+1` bits

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-low
- `start` in 1: request, sampled only in IDLE
- `op` in 1: 0 = MULT (signed), 1 = DIV (signed)
- `a_in` in WIDTH: multiplicand / dividend, from A register
- `b_in` in WIDTH: multiplier / divisor, from B register
- `busy` out 1: operation in progress; main FSM holds while high
- `done` out 1: one-cycle completion pulse
- `hi_lo_write` out 1: one-cycle strobe; drives HI_write and LO_write
- `hi_out` out WIDTH: MULT upper product / DIV remainder
- `lo_out` out WIDTH: MULT lower product / DIV quotient
- `div_zero` out 1: one-cycle pulse, divisor was zero

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE, `start`=1:
  - Latch |a|, |b| and the sign flags.
  - Go to DONE if `op`=1 and `b_in`=0 (div_zero path).
  - Otherwise clear the 2·WIDTH accumulator, set count = WIDTH, go to RUN.
- RUN:
  - MULT: unsigned shift-add, one multiplier bit per cycle, LSB first.
  - DIV: restoring divide, one quotient bit per cycle, MSB first; the partial remainder uses WIDTH+1 bits.
  - Count decrements each cycle; at 0, go to FIX.
- FIX: sign correction by two's-complement negation.
  - MULT: negate the 64-bit product if sign(a)≠sign(b).
  - DIV: negate the quotient if signs differ; the remainder takes the sign of the dividend.
  - Load `hi_out`/`lo_out`, go to DONE.
- DONE:
  - `done`=1 always.
  - `hi_lo_write`=1 unless on the div_zero path, where `div_zero`=1 and `hi_out`/`lo_out` are unchanged.
  - Return to IDLE.
- Edge cases:
  - 0x80000000 ÷ −1 yields quotient 0x80000000, remainder 0 (magnitude arithmetic wraps; no trap).
  - `start` outside IDLE is ignored.
  - `op`, `a_in` and `b_in` are don't-care after the start cycle.

## Timing
- Reset (`reset`=0 at an edge): state IDLE; `busy`, `done`, `hi_lo_write`, `div_zero` = 0; `hi_out` = `lo_out` = 0; count 0. Reset aborts any in-flight operation with no write.
- All outputs are registered.
- Normal op, start sampled at edge E0:
  - `busy` is high from after E0 through the DONE cycle.
  - FIX at E(WIDTH+1).
  - `done` and `hi_lo_write` are high for the one cycle after E(WIDTH+2), i.e. latency WIDTH+2 = 34 cycles.
- div_zero path: `done` and `div_zero` are high for the cycle after E1; `busy` is high 1 cycle.
- `hi_out`/`lo_out` change only at the FIX edge and hold until the next FIX or reset.
- The earliest back-to-back start is the cycle after `done`.

## Configuration
- `MULTDIV_DIV_EN` defined: full behaviour as above.
- Not defined:
  - Divider datapath and remainder logic are removed.
  - A `start` with `op`=1 goes directly to DONE: one `done` pulse after E1, `hi_lo_write`=0, `div_zero`=0, HI/LO unchanged.
  - MULT is unaffected.

## Structure
- Package `mult_div_pkg`:
  - state enum (IDLE, RUN, FIX, DONE)
  - `OP_MULT`/`OP_DIV` constants
  - default `WIDTH`
- Sub-module `sign_fix64`: combinational conditional two's-complement negate of a 2·WIDTH value. It is used for operand magnitude and result correction.

## Test plan
- MULT 7 × 0xFFFFFFFD (−3) → `hi_out`=0xFFFFFFFF, `lo_out`=0xFFFFFFEB; `done` and `hi_lo_write` 34 cycles after start; `busy` high throughout.
- MULT 0x80000000 × 0x80000000 → `hi_out`=0x40000000, `lo_out`=0x00000000.
- DIV 100 ÷ 7 → `lo_out`=14, `hi_out`=2. DIV −100 ÷ 7 → `lo_out`=0xFFFFFFF2, `hi_out`=0xFFFFFFFE.
- DIV 0x80000000 ÷ 0xFFFFFFFF → `lo_out`=0x80000000, `hi_out`=0. DIV 5 ÷ 0 → `div_zero` and `done` after 1 cycle, no `hi_lo_write`, HI/LO keep prior values.
- `start` re-asserted at cycle 5 of a MULT is ignored (single `done`). `reset`=0 at cycle 10 → next cycle `busy`=0, `hi_out`=`lo_out`=0, no strobe ever issued.
- With `MULTDIV_DIV_EN` undefined: DIV 100 ÷ 7 → `done` after 1 cycle, `hi_lo_write`=0, `div_zero`=0.
